bist_march_ctrl: RTL and testbench

//  Sequencer for the memory BIST datapath behind the JTAG TAP. Words loaded by GETTEST
//  (10-bit DR updates) are stored as march elements in a program buffer. RUNBIST (start)

---
 rtl/bist_march_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_bist_march_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bist_march_ctrl.sv
// March-test BIST sequencer: buffers march elements loaded through the TAP and replays them over the RAM.
// Optional build macro BIST_STOP_ON_FAIL_EN: end the run at the first read mismatch.
module bist_march_ctrl #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PROG_DEPTH = 16,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_wr,
  input  logic [9:0]        prog_data,
  input  logic              prog_clr,
  input  logic              start,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AW-1:0]     fail_addr,
  output logic [3:0]        fail_elem,
  output logic [7:0]        err_cnt,
  output logic              prog_ovf
);

  localparam int unsigned CW = $clog2(PROG_DEPTH + 1);
  localparam int unsigned IW = $clog2(PROG_DEPTH);

  localparam logic [1:0] OP_END = 2'b00;
  localparam logic [1:0] OP_W   = 2'b01;
  localparam logic [1:0] OP_RW  = 2'b11;

  typedef struct packed {
    logic       chk;
    logic       bg;
    logic       dir;
    logic [1:0] op;
  } elem_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WRITE, S_RD_ISSUE, S_RD_CHECK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  elem_t             elem_q, elem_d;
  elem_t             prog_mem [PROG_DEPTH];
  elem_t             fetch_w;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     addr_d, fail_addr_d, start_addr, next_addr;
  logic              we_d, busy_d, done_d, pass_d;
  logic [DATA_W-1:0] wdata_d;
  logic [3:0]        fail_elem_d;
  logic [7:0]        err_d;
  logic              mism, last, stop, load_ok;
  logic              unused_prog_bits;

  assign unused_prog_bits = ^prog_data[9:5];

  function automatic logic [DATA_W-1:0] pat(input elem_t e, input logic [AW-1:0] a);
    return {DATA_W{e.bg ^ (e.chk & a[0])}};
  endfunction

  assign fetch_w    = prog_mem[idx_q[IW-1:0]];
  assign start_addr = fetch_w.dir ? AW'(DEPTH - 1) : '0;
  assign next_addr  = elem_q.dir ? ram_addr - AW'(1) : ram_addr + AW'(1);
  assign last       = elem_q.dir ? (ram_addr == '0) : (ram_addr == AW'(DEPTH - 1));
  assign mism       = (ram_rdata != pat(elem_q, ram_addr));
`ifdef BIST_STOP_ON_FAIL_EN
  assign stop       = mism;
`else
  assign stop       = 1'b0;
`endif

  // Program buffer only changes while the sequencer is idle; clear wins over append.
  assign load_ok = (state_q == S_IDLE) && !prog_clr && prog_wr && (count_q != CW'(PROG_DEPTH));

  always_ff @(posedge clk) begin
    if (load_ok) prog_mem[count_q[IW-1:0]] <= elem_t'(prog_data[4:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      prog_ovf <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (prog_clr) begin
        count_q  <= '0;
        prog_ovf <= 1'b0;
      end else if (prog_wr) begin
        if (count_q == CW'(PROG_DEPTH)) prog_ovf <= 1'b1;
        else                            count_q  <= count_q + CW'(1);
      end
    end
  end

  // Next state plus next values of every registered RAM/status output.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    idx_d       = idx_q;
    addr_d      = ram_addr;
    we_d        = 1'b0;
    wdata_d     = ram_wdata;
    busy_d      = busy;
    done_d      = 1'b0;
    pass_d      = pass;
    fail_addr_d = fail_addr;
    fail_elem_d = fail_elem;
    err_d       = err_cnt;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          idx_d       = '0;
          busy_d      = 1'b1;
          pass_d      = 1'b1;
          err_d       = '0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      S_FETCH: begin
        if (idx_q == count_q || fetch_w.op == OP_END) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          elem_d = fetch_w;
          addr_d = start_addr;
          if (fetch_w.op == OP_W) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            wdata_d = pat(fetch_w, start_addr);
          end else begin
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_WRITE: begin
        if (last) begin
          state_d = S_FETCH;
          idx_d   = idx_q + CW'(1);
        end else begin
          addr_d  = next_addr;
          we_d    = 1'b1;
          wdata_d = pat(elem_q, next_addr);
        end
      end
      S_RD_ISSUE: begin
        state_d = S_RD_CHECK;
        if (elem_q.op == OP_RW) begin
          we_d    = 1'b1;
          wdata_d = ~pat(elem_q, ram_addr);
        end
      end
      S_RD_CHECK: begin
        if (mism) begin
          pass_d = 1'b0;
          err_d  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
          if (pass) begin
            fail_addr_d = ram_addr;
            fail_elem_d = 4'(idx_q);
          end
        end
        if (stop) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (last) begin
          state_d = S_FETCH;
          idx_d   = idx_q + CW'(1);
        end else begin
          state_d = S_RD_ISSUE;
          addr_d  = next_addr;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      elem_q    <= '0;
      idx_q     <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b1;
      fail_addr <= '0;
      fail_elem <= '0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      idx_q     <= idx_d;
      ram_addr  <= addr_d;
      ram_we    <= we_d;
      ram_wdata <= wdata_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      fail_addr <= fail_addr_d;
      fail_elem <= fail_elem_d;
      err_cnt   <= err_d;
    end
  end

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Directed bench for bist_march_ctrl: behavioural RAM with optional stuck-at-1 bit, hand-computed results.
module tb_bist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, prog_wr, prog_clr, start;
  logic [9:0] prog_data;
  logic [7:0] ram_addr, ram_wdata, ram_rdata, fail_addr, err_cnt;
  logic       ram_we, busy, done, pass, prog_ovf;
  logic [3:0] fail_elem;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [256];
  logic       stuck_en = 1'b0;
  logic       mon_en   = 1'b0;
  int         w_cnt, pat_err, ord_err;
  logic [7:0] first_addr, last_addr;

  always #5 clk = ~clk;

  bist_march_ctrl dut (
    .clk(clk), .rst_n(rst_n), .prog_wr(prog_wr), .prog_data(prog_data),
    .prog_clr(prog_clr), .start(start), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .done(done),
    .pass(pass), .fail_addr(fail_addr), .fail_elem(fail_elem), .err_cnt(err_cnt),
    .prog_ovf(prog_ovf)
  );

  // Synchronous-read RAM; bit 0 of address 0x5A reads as 1 when the fault is enabled.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr] | ((stuck_en && ram_addr == 8'h5A) ? 8'h01 : 8'h00);
  end

  // Write-stream monitor for the checkerboard descending pass.
  always @(negedge clk) begin
    if (mon_en && ram_we) begin
      if (w_cnt == 0) first_addr = ram_addr;
      else if (ram_addr != last_addr - 8'd1) ord_err++;
      if (ram_wdata != (ram_addr[0] ? 8'h00 : 8'hFF)) pat_err++;
      last_addr = ram_addr;
      w_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] w);
    prog_data = w;
    prog_wr   = 1'b1;
    tick();
    prog_wr   = 1'b0;
  endtask

  task automatic clr();
    prog_clr = 1'b1;
    tick();
    prog_clr = 1'b0;
  endtask

  // Pulse start; n = cycle number (after start was sampled) in which done is seen.
  task automatic run(input string tag, output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    while (!done && n < 6000) begin
      tick();
      n++;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    tick();
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  int n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; prog_wr = 1'b0; prog_clr = 1'b0; start = 1'b0; prog_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd1);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_faddr", 32'(fail_addr), 32'd0);
    check("rst_felem", 32'(fail_elem), 32'd0);
    check("rst_ovf", 32'(prog_ovf), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);

    run("empty", n);
    check("empty_cycles", 32'(n), 32'd2);
    check("empty_pass", 32'(pass), 32'd1);

    // W0, RW0, R1 ascending on a good RAM
    load(10'h001); load(10'h003); load(10'h00A);
    run("t1", n);
    check("t1_cycles", 32'(n), 32'd1285);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_err", 32'(err_cnt), 32'd0);

    // Same program with stuck bit: only the RW read of 0x5A sees it
    stuck_en = 1'b1;
    run("t2", n);
`ifdef BIST_STOP_ON_FAIL_EN
    check("t2_cycles", 32'(n), 32'd441);
`else
    check("t2_cycles", 32'(n), 32'd1285);
`endif
    check("t2_pass", 32'(pass), 32'd0);
    check("t2_faddr", 32'(fail_addr), 32'h5A);
    check("t2_felem", 32'(fail_elem), 32'd1);
    check("t2_err", 32'(err_cnt), 32'd1);

    // W0, R0, RW0: two reads of 0x5A expect 0
    clr(); load(10'h001); load(10'h002); load(10'h003);
    run("t2b", n);
`ifdef BIST_STOP_ON_FAIL_EN
    check("t2b_cycles", 32'(n), 32'd441);
    check("t2b_err", 32'(err_cnt), 32'd1);
`else
    check("t2b_cycles", 32'(n), 32'd1285);
    check("t2b_err", 32'(err_cnt), 32'd2);
`endif
    check("t2b_faddr", 32'(fail_addr), 32'h5A);
    check("t2b_felem", 32'(fail_elem), 32'd1);

    // Checkerboard, bg=1, descending write then read
    stuck_en = 1'b0;
    clr(); load(10'h01D); load(10'h01E);
    w_cnt = 0; pat_err = 0; ord_err = 0; mon_en = 1'b1;
    run("t3", n);
    mon_en = 1'b0;
    check("t3_cycles", 32'(n), 32'd772);
    check("t3_pass", 32'(pass), 32'd1);
    check("t3_wcnt", 32'(w_cnt), 32'd256);
    check("t3_first", 32'(first_addr), 32'd255);
    check("t3_last", 32'(last_addr), 32'd0);
    check("t3_pat", 32'(pat_err), 32'd0);
    check("t3_order", 32'(ord_err), 32'd0);

    // W, END, R with stuck fault: R must not run
    stuck_en = 1'b1;
    clr(); load(10'h001); load(10'h000); load(10'h002);
    run("t6", n);
    check("t6_cycles", 32'(n), 32'd259);
    check("t6_pass", 32'(pass), 32'd1);
    stuck_en = 1'b0;

    // Overflow: 17 writes into 16 entries
    clr();
    for (int i = 0; i < 16; i++) load(10'h001);
    check("t4_ovf_full", 32'(prog_ovf), 32'd0);
    load(10'h000);
    check("t4_ovf", 32'(prog_ovf), 32'd1);
    run("t4", n);
    check("t4_cycles", 32'(n), 32'd4114);
    clr();
    check("t4_ovf_clr", 32'(prog_ovf), 32'd0);
    run("t4e", n);
    check("t4e_cycles", 32'(n), 32'd2);
    load(10'h001);
    prog_data = 10'h001; prog_wr = 1'b1; prog_clr = 1'b1;
    tick();
    prog_wr = 1'b0; prog_clr = 1'b0;
    run("t4p", n);
    check("t4p_cycles", 32'(n), 32'd2);

    // start and prog_wr mid-run are ignored
    load(10'h001);
    start = 1'b1; tick(); start = 1'b0;
    n = 1;
    while (!done && n < 6000) begin
      if (n == 100) begin start = 1'b1; prog_wr = 1'b1; prog_data = 10'h002; end
      else begin start = 1'b0; prog_wr = 1'b0; end
      tick();
      n++;
    end
    start = 1'b0; prog_wr = 1'b0;
    check("t5_cycles", 32'(n), 32'd259);
    tick();
    run("t5b", n);
    check("t5b_cycles", 32'(n), 32'd259);

    // Reset during an RW check cycle
    clr(); load(10'h001); load(10'h003);
    start = 1'b1; tick(); start = 1'b0;
    n = 1;
    while (n < 500) begin tick(); n++; end
    check("t5_we_pre", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_we", 32'(ram_we), 32'd0);
    check("t5_rst_pass", 32'(pass), 32'd1);
    run("t5e", n);
    check("t5e_cycles", 32'(n), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
